rgb_to_yuv: RTL

Pipelined BT.601 studio-range colour-space converter from RGB to YCbCr (YUV), the forward-direction counterpart of the JPEG viewer's YUV-to-RGB stage. It feeds the encode/capture path ahead of the DCT/JPEG encoder. It accepts one RGB pixel per cycle on a valid/ready stream and emits Y/U/V with line sideband. It optionally averages chroma over pixel pairs (4:2:2).

---
 rtl/rgb_to_yuv.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rgb_to_yuv.sv
// rgb_to_yuv: four-stage BT.601 studio-range RGB -> YCbCr converter on a valid/ready stream.
// Define RGB_TO_YUV_422_EN to average chroma over even/odd pixel pairs (4:2:2 output).
module rgb_to_yuv #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_sysclk,
    input  logic                  i_arstn,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_sol,
    input  logic                  i_eol,
    input  logic [DATA_WIDTH-1:0] i_R,
    input  logic [DATA_WIDTH-1:0] i_G,
    input  logic [DATA_WIDTH-1:0] i_B,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_sol,
    output logic                  o_eol,
    output logic [DATA_WIDTH-1:0] o_Y,
    output logic [DATA_WIDTH-1:0] o_U,
    output logic [DATA_WIDTH-1:0] o_V
);
    localparam int W  = DATA_WIDTH;
    localparam int SW = DATA_WIDTH + 10;

    localparam logic signed [SW-1:0] K_YR  = SW'(66);
    localparam logic signed [SW-1:0] K_YG  = SW'(129);
    localparam logic signed [SW-1:0] K_YB  = SW'(25);
    localparam logic signed [SW-1:0] K_UR  = SW'(-38);
    localparam logic signed [SW-1:0] K_UG  = SW'(-74);
    localparam logic signed [SW-1:0] K_UB  = SW'(112);
    localparam logic signed [SW-1:0] K_VR  = SW'(112);
    localparam logic signed [SW-1:0] K_VG  = SW'(-94);
    localparam logic signed [SW-1:0] K_VB  = SW'(-18);
    localparam logic signed [SW-1:0] ROUND = SW'(128);
    localparam logic signed [SW-1:0] Y_OFF = SW'(16 << (W - 8));
    localparam logic signed [SW-1:0] C_OFF = SW'(128 << (W - 8));
    localparam logic signed [SW-1:0] MAXV  = SW'((1 << W) - 1);

    typedef struct packed {
        logic         sol;
        logic         eol;
        logic [W-1:0] y;
        logic [W-1:0] u;
        logic [W-1:0] v;
    } beat_t;

    // Handshake: a pixel moves on a cycle where valid and ready are both high; the
    // whole pipe advances together when the output register is empty or drained.
    logic advance;
    logic pipe_adv;
    logic accept;

    logic                 s1_vld_q, s1_sol_q, s1_eol_q;
    logic [W-1:0]         s1_r_q, s1_g_q, s1_b_q;
    logic                 s2_vld_q, s2_sol_q, s2_eol_q;
    logic signed [SW-1:0] s2_p_q [9];
    logic signed [SW-1:0] prod_d [9];
    logic                 s3_vld_q, s3_sol_q, s3_eol_q;
    logic signed [SW-1:0] s3_y_q, s3_u_q, s3_v_q;
    logic signed [SW-1:0] r_s, g_s, b_s;

    beat_t                new_beat;
    logic                 out_vld_q, out_vld_d;
    beat_t                out_q, out_d;

    function automatic logic [W-1:0] clamp_sat(input logic signed [SW-1:0] x);
        logic [W-1:0] r;
        r = x[W-1:0];
        if (x[SW-1]) begin
            r = '0;
        end else if (x > MAXV) begin
            r = '1;
        end
        return r;
    endfunction

    assign advance = !out_vld_q || i_ready;
    assign accept  = i_valid && pipe_adv;
    assign o_ready = pipe_adv;

`ifdef RGB_TO_YUV_422_EN
    logic phase_q;
    logic px_odd;
    logic s1_odd_q, s2_odd_q, s3_odd_q;

    assign px_odd = phase_q && !i_sol;

    always_ff @(posedge i_sysclk or negedge i_arstn) begin
        if (!i_arstn) begin
            phase_q <= 1'b0;
        end else if (accept) begin
            // An even pixel that ends a line has no partner, so the next one is even again.
            phase_q <= !px_odd && !i_eol;
        end
    end
`endif

    assign r_s = $signed(SW'(s1_r_q));
    assign g_s = $signed(SW'(s1_g_q));
    assign b_s = $signed(SW'(s1_b_q));

    assign prod_d[0] = r_s * K_YR;
    assign prod_d[1] = g_s * K_YG;
    assign prod_d[2] = b_s * K_YB;
    assign prod_d[3] = r_s * K_UR;
    assign prod_d[4] = g_s * K_UG;
    assign prod_d[5] = b_s * K_UB;
    assign prod_d[6] = r_s * K_VR;
    assign prod_d[7] = g_s * K_VG;
    assign prod_d[8] = b_s * K_VB;

    always_ff @(posedge i_sysclk or negedge i_arstn) begin
        if (!i_arstn) begin
            s1_vld_q <= 1'b0;
            s1_sol_q <= 1'b0;
            s1_eol_q <= 1'b0;
            s1_r_q   <= '0;
            s1_g_q   <= '0;
            s1_b_q   <= '0;
            s2_vld_q <= 1'b0;
            s2_sol_q <= 1'b0;
            s2_eol_q <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                s2_p_q[i] <= '0;
            end
            s3_vld_q <= 1'b0;
            s3_sol_q <= 1'b0;
            s3_eol_q <= 1'b0;
            s3_y_q   <= '0;
            s3_u_q   <= '0;
            s3_v_q   <= '0;
`ifdef RGB_TO_YUV_422_EN
            s1_odd_q <= 1'b0;
            s2_odd_q <= 1'b0;
            s3_odd_q <= 1'b0;
`endif
        end else if (pipe_adv) begin
            s1_vld_q <= i_valid;
            if (i_valid) begin
                s1_sol_q <= i_sol;
                s1_eol_q <= i_eol;
                s1_r_q   <= i_R;
                s1_g_q   <= i_G;
                s1_b_q   <= i_B;
`ifdef RGB_TO_YUV_422_EN
                s1_odd_q <= px_odd;
`endif
            end
            s2_vld_q <= s1_vld_q;
            s2_sol_q <= s1_sol_q;
            s2_eol_q <= s1_eol_q;
            s2_p_q   <= prod_d;
            s3_vld_q <= s2_vld_q;
            s3_sol_q <= s2_sol_q;
            s3_eol_q <= s2_eol_q;
            s3_y_q   <= s2_p_q[0] + s2_p_q[1] + s2_p_q[2] + ROUND;
            s3_u_q   <= s2_p_q[3] + s2_p_q[4] + s2_p_q[5] + ROUND;
            s3_v_q   <= s2_p_q[6] + s2_p_q[7] + s2_p_q[8] + ROUND;
`ifdef RGB_TO_YUV_422_EN
            s2_odd_q <= s1_odd_q;
            s3_odd_q <= s2_odd_q;
`endif
        end
    end

    always_comb begin
        new_beat     = '0;
        new_beat.sol = s3_sol_q;
        new_beat.eol = s3_eol_q;
        new_beat.y   = clamp_sat((s3_y_q >>> 8) + Y_OFF);
        new_beat.u   = clamp_sat((s3_u_q >>> 8) + C_OFF);
        new_beat.v   = clamp_sat((s3_v_q >>> 8) + C_OFF);
    end

`ifdef RGB_TO_YUV_422_EN
    logic  pend_vld_q, pend_vld_d;
    beat_t pend_q, pend_d;
    logic  buf_vld_q, buf_vld_d;
    beat_t buf_q, buf_d;
    beat_t pair_even, pair_odd;

    // (a+b+1)>>1 rewritten so it never needs a W+1-bit intermediate.
    function automatic logic [W-1:0] avg2(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a >> 1) + (b >> 1) + W'(a[0] | b[0]);
    endfunction

    // The second beat of a pair sits in pend_q; the pipe is frozen until it moves out.
    assign pipe_adv = advance && !pend_vld_q;

    always_comb begin
        out_vld_d  = out_vld_q;
        out_d      = out_q;
        pend_vld_d = pend_vld_q;
        pend_d     = pend_q;
        buf_vld_d  = buf_vld_q;
        buf_d      = buf_q;
        pair_even     = buf_q;
        pair_even.eol = 1'b0;
        pair_even.u   = avg2(buf_q.u, new_beat.u);
        pair_even.v   = avg2(buf_q.v, new_beat.v);
        pair_odd      = new_beat;
        pair_odd.u    = pair_even.u;
        pair_odd.v    = pair_even.v;
        if (advance) begin
            if (pend_vld_q) begin
                out_vld_d  = 1'b1;
                out_d      = pend_q;
                pend_vld_d = 1'b0;
            end else begin
                out_vld_d = 1'b0;
                if (s3_vld_q) begin
                    if (s3_odd_q && buf_vld_q) begin
                        out_vld_d  = 1'b1;
                        out_d      = pair_even;
                        pend_vld_d = 1'b1;
                        pend_d     = pair_odd;
                        buf_vld_d  = 1'b0;
                    end else if (!s3_odd_q && !s3_eol_q) begin
                        // A still-buffered even pixel here lost its partner to a new line.
                        if (buf_vld_q) begin
                            out_vld_d = 1'b1;
                            out_d     = buf_q;
                        end
                        buf_vld_d = 1'b1;
                        buf_d     = new_beat;
                    end else if (buf_vld_q) begin
                        out_vld_d  = 1'b1;
                        out_d      = buf_q;
                        pend_vld_d = 1'b1;
                        pend_d     = new_beat;
                        buf_vld_d  = 1'b0;
                    end else begin
                        out_vld_d = 1'b1;
                        out_d     = new_beat;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_sysclk or negedge i_arstn) begin
        if (!i_arstn) begin
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
            buf_vld_q  <= 1'b0;
            buf_q      <= '0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
            buf_vld_q  <= buf_vld_d;
            buf_q      <= buf_d;
        end
    end
`else
    assign pipe_adv = advance;

    always_comb begin
        out_vld_d = out_vld_q;
        out_d     = out_q;
        if (advance) begin
            out_vld_d = s3_vld_q;
            if (s3_vld_q) begin
                out_d = new_beat;
            end
        end
    end
`endif

    always_ff @(posedge i_sysclk or negedge i_arstn) begin
        if (!i_arstn) begin
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
        end
    end

    assign o_valid = out_vld_q;
    assign o_sol   = out_q.sol;
    assign o_eol   = out_q.eol;
    assign o_Y     = out_q.y;
    assign o_U     = out_q.u;
    assign o_V     = out_q.v;

endmodule
